// File: rtl/wptr_full_level.sv
// Write-domain pointer/status for the dual-clock FIFO: Gray write pointer, binary
// address, registered fill level, programmable almost-full and sticky overflow.
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   awfull_thresh,
    input  logic                wovf_clr,
    output logic                wfull,
    output logic                awfull,
    output logic                woverflow,
    output logic [ADDRSIZE:0]   wlevel,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr
);

    localparam logic [ADDRSIZE:0] DEPTH = (ADDRSIZE+1)'(1 << ADDRSIZE);

    logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rbin_s, level_next, free_next;
    logic              wacc;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
        assign rbin_s[i] = ^(wq2_rptr >> i);
    end

    assign wacc       = winc & ~wfull;
    assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wacc};
    assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
    assign level_next = wbinnext - rbin_s;
    assign free_next  = DEPTH - level_next;
    assign waddr      = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wlevel    <= '0;
            wfull     <= 1'b0;
            awfull    <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbinnext;
            wptr      <= wgraynext;
            wlevel    <= level_next;
            wfull     <= (level_next == DEPTH);
            awfull    <= (free_next <= awfull_thresh);
            // A new overflow event takes priority over a same-cycle clear.
            woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed plus randomized checks of wptr_full_level against a count-based model.
module tb_wptr_full_level;

    localparam int AS = 4;
    localparam int D  = 16;

    logic          wclk, wrst_n, winc, wovf_clr;
    logic [AS:0]   wq2_rptr, awfull_thresh;
    logic          wfull, awfull, woverflow;
    logic [AS:0]   wlevel, wptr, prev_wptr;
    logic [AS-1:0] waddr;

    int n_tests = 0, n_fail = 0;
    // Model state: total accepted writes, flags as the spec defines them.
    int m_wr, m_lvl, rd;
    bit m_full, m_aw, m_ovf;

    wptr_full_level #(.ADDRSIZE(AS)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .awfull_thresh(awfull_thresh), .wovf_clr(wovf_clr), .wfull(wfull),
        .awfull(awfull), .woverflow(woverflow), .wlevel(wlevel), .waddr(waddr),
        .wptr(wptr)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [AS:0] gray(int n);
        logic [AS:0] b;
        b = n[AS:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".wptr"},   32'(wptr),      32'(gray(m_wr)));
        chk({tag, ".waddr"},  32'(waddr),     32'(m_wr % D));
        chk({tag, ".wlevel"}, 32'(wlevel),    32'(m_lvl));
        chk({tag, ".wfull"},  32'(wfull),     32'(m_full));
        chk({tag, ".awfull"}, 32'(awfull),    32'(m_aw));
        chk({tag, ".wovf"},   32'(woverflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        m_wr = 0; m_lvl = 0; rd = 0;
        m_full = 0; m_aw = 0; m_ovf = 0;
    endtask

    // One clock: drive inputs, update model from the spec's rules, check after edge.
    task automatic cyc(string tag, bit w, int r, int th, bit c);
        bit acc;
        winc = w; wq2_rptr = gray(r); awfull_thresh = th[AS:0]; wovf_clr = c;
        acc   = w && !m_full;
        m_ovf = (w && m_full) || (m_ovf && !c);
        m_wr  = m_wr + int'(acc);
        m_lvl = m_wr - r;
        m_full = (m_lvl == D);
        m_aw   = ((D - m_lvl) <= th);
        @(posedge wclk);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        #1;
        model_reset();
        chk_all("reset");
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        int h1, h2, adv, hd;
        winc = 0; wovf_clr = 0; wq2_rptr = '0; awfull_thresh = 5'd3;
        do_reset();

        // Fill from empty with thresh=3, then one write while full.
        for (int i = 0; i < 16; i++) cyc("fill", 1, 0, 3, 0);
        chk("full_after16", 32'(wfull), 32'd1);
        cyc("ovf17", 1, 0, 3, 0);
        chk("wptr_hold", 32'(wptr), 32'b11000);
        cyc("ovf_clr", 0, 0, 3, 1);
        cyc("ovf_set_wins", 1, 0, 3, 1);
        // Read advances while full and writing.
        cyc("rd_while_full", 1, 1, 3, 0);
        chk("drop_to15", 32'(wlevel), 32'd15);
        cyc("refill", 1, 1, 3, 0);

        // thresh=0: awfull tracks wfull.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc("th0", 1, 0, 0, 0);
            chk("th0_track", 32'(awfull), 32'(wfull));
        end

        // thresh=16: awfull from the first edge.
        do_reset();
        cyc("th16", 0, 0, 16, 0);
        chk("th16_first", 32'(awfull), 32'd1);

        // Wrap: every write read back two cycles later.
        do_reset();
        h1 = 0; h2 = 0; prev_wptr = wptr;
        for (int i = 0; i < 40; i++) begin
            cyc("wrap", 1, h2, 3, 0);
            hd = $countones(wptr ^ prev_wptr);
            chk("wrap_hamming", 32'(hd), 32'd1);
            chk("wrap_lvl_le3", 32'(wlevel <= 3), 32'd1);
            prev_wptr = wptr;
            h2 = h1; h1 = m_wr;
        end

        // Async reset mid-burst at level 9.
        do_reset();
        for (int i = 0; i < 9; i++) cyc("burst", 1, 0, 3, 0);
        chk("burst_lvl9", 32'(wlevel), 32'd9);
        wrst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge wclk);
        wrst_n = 1'b1;
        wq2_rptr = '0;
        cyc("post_rst", 1, 0, 3, 0);
        chk("post_rst_first", 32'(waddr), 32'd1);

        // Randomized traffic with a lagging, monotonic read pointer.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            adv = m_wr - rd;
            if (adv > 2) adv = 2;
            if ($urandom_range(0, 2) == 0) rd = rd + int'($urandom_range(0, adv));
            cyc("rand", bit'($urandom_range(0, 3) != 0), rd,
                int'($urandom_range(0, 17)), bit'($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
